// File: rtl/instr_loader.sv
// instr_loader: turns the host's 8-bit instruction byte stream into 32-bit
// words and writes them into the core's instruction memory from word 0 up.
// The core stays stalled (cpu_run_o=0) until every memory word has been
// written. Words the host never sent are filled with NOP_WORD.
//
// Handshake: a byte transfers on a rising edge where byte_valid_i=1 and
// byte_ready_o=1. byte_ready_o is combinational and depends only on the FSM
// state (1 in LOAD). A cycle with byte_valid_i=0 changes nothing. The host
// must hold byte_i stable while byte_valid_i=1.
module instr_loader #(
  parameter int          NUM_INSTR = 64,
  parameter int          IDX_W     = 6,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  input  logic             load_end_i,
  output logic             byte_ready_o,
  output logic             imem_we_o,
  output logic [IDX_W-1:0] imem_addr_o,
  output logic [31:0]      imem_wdata_o,
  output logic             cpu_run_o,
  output logic             err_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_PAD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INSTR - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Registered state
  state_t           r_state;
  logic [1:0]       r_byte_cnt;
  logic [IDX_W-1:0] r_word_cnt;
  logic [31:0]      r_asm;
  logic             r_we;
  logic [IDX_W-1:0] r_addr;
  logic [31:0]      r_wdata;
  logic             r_run;
  logic             r_err;

  // Next-state values
  state_t           w_state_nxt;
  logic [1:0]       w_byte_cnt_nxt;
  logic [IDX_W-1:0] w_word_cnt_nxt;
  logic [31:0]      w_asm_nxt;
  logic             w_we_nxt;
  logic [IDX_W-1:0] w_addr_nxt;
  logic [31:0]      w_wdata_nxt;
  logic             w_run_nxt;
  logic             w_err_nxt;

  // Datapath helpers
  logic             w_accept;
  logic [1:0]       w_lane;
  logic [31:0]      w_asm_ins;
  logic [31:0]      w_asm_cur;
  logic             w_word_full;
  logic             w_has_partial;
  logic             w_last_word;

  assign byte_ready_o = (r_state == S_LOAD);
  assign w_accept     = byte_valid_i && byte_ready_o;

  // The byte counter picks the lane: the first byte lands in [31:24] when
  // MSB_FIRST is set, otherwise in [7:0].
  assign w_lane = MSB_FIRST ? (2'd3 - r_byte_cnt) : r_byte_cnt;

  // Assembly register with the incoming byte dropped into its lane
  always_comb begin
    w_asm_ins = r_asm;
    w_asm_ins[{w_lane, 3'b000} +: 8] = byte_i;
  end

  // The word as it stands after this cycle's byte, if there is one. Lanes
  // not yet received are still zero because the register is cleared after
  // every write.
  assign w_asm_cur     = w_accept ? w_asm_ins : r_asm;
  assign w_word_full   = w_accept && (r_byte_cnt == 2'd3);
  assign w_has_partial = w_accept || (r_byte_cnt != 2'd0);
  assign w_last_word   = (r_word_cnt == LAST_IDX);

  // Next-state and output logic. A byte that arrives together with
  // load_end_i is taken first, and the end condition includes it.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_asm_nxt      = r_asm;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_run_nxt      = r_run;
    w_err_nxt      = r_err;

    unique case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          w_asm_nxt      = w_asm_ins;
        end
        if (w_word_full || (load_end_i && w_has_partial)) begin
          // Register the word. The strobe goes out in the next cycle.
          w_we_nxt       = 1'b1;
          w_addr_nxt     = r_word_cnt;
          w_wdata_nxt    = w_asm_cur;
          w_word_cnt_nxt = r_word_cnt + IDX_ONE;
          w_asm_nxt      = '0;
          w_byte_cnt_nxt = 2'd0;
          if (!w_word_full) begin
            w_err_nxt = 1'b1;
          end
          if (w_last_word) begin
            w_state_nxt = S_DONE;
          end else if (load_end_i) begin
            w_state_nxt = S_PAD;
          end
        end else if (load_end_i) begin
          // End on a word boundary: nothing to write this cycle.
          w_state_nxt = S_PAD;
        end
      end

      S_PAD: begin
        // One NOP per cycle at consecutive indices, up to the top word
        w_we_nxt       = 1'b1;
        w_addr_nxt     = r_word_cnt;
        w_wdata_nxt    = NOP_WORD;
        w_word_cnt_nxt = r_word_cnt + IDX_ONE;
        if (w_last_word) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // Entered on the edge that issues the final strobe, so run rises
        // one cycle after that strobe.
        w_run_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // State register; async reset restarts the load from word 0
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state    <= S_LOAD;
      r_byte_cnt <= 2'd0;
      r_word_cnt <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_run      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_asm      <= w_asm_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_run      <= w_run_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;
  assign cpu_run_o    = r_run;
  assign err_o        = r_err;
  assign dbg_state_o  = r_state;

endmodule
